// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack
// instruction-memory interface and presents {instruction, PC+step, valid}
// to decode through the IF/ID output register. A one-entry skid buffer
// absorbs a fetch that completes during a hazard freeze. A taken branch
// from execute redirects the PC and flushes the stage.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    // FETCH   : request at pc.
    // DISCARD : a request issued before a branch is still in flight; keep
    //           presenting its address and throw its data away.
    // STALL   : skid buffer full, no request issued.
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic        buf_valid_q;
    logic [31:0] buf_instr_q;
    logic [31:0] buf_pc_q;
    logic        if_valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;

    // Sequential successor of the current fetch address (32-bit wrap).
    logic [31:0] pc_plus_step;
    assign pc_plus_step = pc_q + PC_STEP;

    // Memory request is decoded straight from registered state, so the
    // address cannot move while a request is waiting for its ack.
    assign imem_req  = (state_q != STALL);
    assign imem_addr = (state_q == DISCARD) ? req_addr_q : pc_q;

    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instruction = if_instr_q;

    // Fetch FSM: PC, in-flight address, skid buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state is assigned with <= only, so every
            // register here samples the values from before this edge.
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            buf_valid_q <= 1'b0;
            // NOTE: buffer payload is reset too; it is only two words and
            // keeps the datapath free of X after reset.
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (branch_taken) begin
                        pc_q <= branch_addr;
                        if (!imem_ack) begin
                            // Old request still pending: remember its address.
                            req_addr_q <= pc_q;
                            state_q    <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc_q <= pc_plus_step;
                        if (freeze) begin
                            buf_valid_q <= 1'b1;
                            buf_pc_q    <= pc_plus_step;
                            buf_instr_q <= imem_rdata;
                            state_q     <= STALL;
                        end
                    end
                end
                DISCARD: begin
                    if (branch_taken) begin
                        pc_q <= branch_addr;
                    end
                    if (imem_ack) begin
                        state_q <= FETCH;
                    end
                end
                STALL: begin
                    if (branch_taken) begin
                        buf_valid_q <= 1'b0;
                        pc_q        <= branch_addr;
                        state_q     <= FETCH;
                    end else if (!freeze) begin
                        buf_valid_q <= 1'b0;
                        state_q     <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    // IF/ID output register: branch flush > freeze hold > buffer > memory > bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else if (branch_taken) begin
            if_valid_q <= 1'b0;
        end else if (freeze) begin
            if_valid_q <= if_valid_q;
        end else if (state_q == STALL) begin
            if_valid_q <= buf_valid_q;
            if_pc_q    <= buf_pc_q;
            if_instr_q <= buf_instr_q;
        end else if ((state_q == FETCH) && imem_ack) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_plus_step;
            if_instr_q <= imem_rdata;
        end else begin
            if_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against an instruction-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model controls.
    int          cur_lat  = 0;      // extra wait cycles before ack
    bit          rand_lat = 1'b0;   // pick a fresh latency per request
    logic [31:0] salt     = '0;     // word = address ^ salt
    bit          outstanding = 1'b0;
    int          cnt = 0;
    logic [31:0] held_addr = '0;

    fetch_stage #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ salt;
    endfunction

    // Instruction memory: driven on the falling edge, checks address stability.
    always @(negedge clk) begin
        logic [31:0] junk;
        if (imem_ack) outstanding = 1'b0;
        imem_ack = 1'b0;
        junk = $urandom;
        imem_rdata = junk;
        if (!rst) begin
            outstanding = 1'b0;
        end else if (imem_req) begin
            if (!outstanding) begin
                outstanding = 1'b1;
                cnt = 0;
                held_addr = imem_addr;
                if (rand_lat) cur_lat = $urandom_range(0, 3);
            end else begin
                n_tests++;
                if (imem_addr !== held_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable got %h required %h", imem_addr, held_addr);
                end
            end
            if (cnt >= cur_lat) begin
                imem_ack = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end
            cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        freeze = 1'b0;
        branch_taken = 1'b0;
        rand_lat = 1'b0;
        cur_lat = 0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        for (int i = 0; i < 64; i++) begin
            if (imem_addr === a) break;
            step();
        end
        n_tests++;
        if (imem_addr !== a) begin
            n_fail++;
            $display("FAIL wait_addr got %h required %h", imem_addr, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b required 0", if_valid); end
        n_tests++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h required 0", if_pc); end
        n_tests++; if (if_instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h required 0", if_instruction); end
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req got %b required 1", imem_req); end
        n_tests++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_addr got %h required %h", imem_addr, RESET_PC); end
        rst = 1'b1;
    endtask

    task automatic test_zero_wait();
        salt = 32'h0;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step();
            n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d] got %b required 1", i, if_valid); end
            n_tests++; if (if_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL zw_pc[%0d] got %h required %h", i, if_pc, 32'(4 * i)); end
            n_tests++; if (if_instruction !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL zw_instr[%0d] got %h required %h", i, if_instruction, 32'(4 * (i - 1))); end
        end
    endtask

    task automatic test_latency();
        salt = 32'h5A5A_0000;
        do_reset();
        wait_addr(32'h10);
        cur_lat = 2;
        for (int i = 1; i <= 2; i++) begin
            step();
            n_tests++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL lat_addr[%0d] got %h required 10", i, imem_addr); end
            n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL lat_wait_valid[%0d] got %b required 0", i, if_valid); end
        end
        step();
        n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b required 1", if_valid); end
        n_tests++; if (if_pc !== 32'h14) begin n_fail++; $display("FAIL lat_pc got %h required 14", if_pc); end
        n_tests++; if (if_instruction !== mem_word(32'h10)) begin n_fail++; $display("FAIL lat_instr got %h required %h", if_instruction, mem_word(32'h10)); end
        step();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL lat_after_valid got %b required 0", if_valid); end
    endtask

    task automatic test_freeze();
        salt = 32'hC0DE_0000;
        do_reset();
        wait_addr(32'h8);
        freeze = 1'b1;
        cur_lat = 1;
        step();
        n_tests++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL frz_req_wait got %b required 1", imem_req); end
        for (int i = 2; i <= 4; i++) begin
            step();
            n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL frz_req[%0d] got %b required 0", i, imem_req); end
            n_tests++; if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h8, mem_word(32'h4)}) begin
                n_fail++; $display("FAIL frz_hold[%0d] got %b/%h/%h required 1/8/%h", i, if_valid, if_pc, if_instruction, mem_word(32'h4));
            end
        end
        freeze = 1'b0;
        cur_lat = 0;
        step();
        n_tests++; if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'hC, mem_word(32'h8)}) begin
            n_fail++; $display("FAIL frz_release got %b/%h/%h required 1/c/%h", if_valid, if_pc, if_instruction, mem_word(32'h8));
        end
        step();
        n_tests++; if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h10, mem_word(32'hC)}) begin
            n_fail++; $display("FAIL frz_next got %b/%h/%h required 1/10/%h", if_valid, if_pc, if_instruction, mem_word(32'hC));
        end
    endtask

    task automatic test_branch_discard();
        salt = 32'h1234_5678;
        do_reset();
        wait_addr(32'h20);
        cur_lat = 2;
        step();
        n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_addr0 got %h required 20", imem_addr); end
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        step();
        branch_taken = 1'b0;
        branch_addr = 32'hDEAD_BEEC;
        n_tests++; if (imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_addr_held got %h required 20", imem_addr); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid1 got %b required 0", if_valid); end
        step();
        cur_lat = 0;
        n_tests++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_next_addr got %h required 100", imem_addr); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid2 got %b required 0", if_valid); end
        step();
        n_tests++; if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h104, mem_word(32'h100)}) begin
            n_fail++; $display("FAIL br_target got %b/%h/%h required 1/104/%h", if_valid, if_pc, if_instruction, mem_word(32'h100));
        end
    endtask

    task automatic test_branch_in_stall();
        salt = 32'h0F0F_F0F0;
        do_reset();
        wait_addr(32'h8);
        freeze = 1'b1;
        step();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bs_stall_req got %b required 0", imem_req); end
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        step();
        branch_taken = 1'b0;
        freeze = 1'b0;
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL bs_valid got %b required 0", if_valid); end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL bs_restart got %b/%h required 1/200", imem_req, imem_addr); end
        step();
        n_tests++; if ({if_valid, if_pc, if_instruction} !== {1'b1, 32'h204, mem_word(32'h200)}) begin
            n_fail++; $display("FAIL bs_target got %b/%h/%h required 1/204/%h", if_valid, if_pc, if_instruction, mem_word(32'h200));
        end
    endtask

    task automatic test_async_reset();
        salt = 32'hAAAA_5555;
        do_reset();
        wait_addr(32'h40);
        cur_lat = 3;
        step();
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if ({if_valid, if_pc, if_instruction} !== {1'b0, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL ar_clear got %b/%h/%h required 0/0/0", if_valid, if_pc, if_instruction);
        end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin n_fail++; $display("FAIL ar_addr got %b/%h required 1/%h", imem_req, imem_addr, RESET_PC); end
        step();
        rst = 1'b1;
        cur_lat = 0;
        step();
        n_tests++; if ({if_valid, if_pc, if_instruction} !== {1'b1, RESET_PC + 32'd4, mem_word(RESET_PC)}) begin
            n_fail++; $display("FAIL ar_first got %b/%h/%h required 1/%h/%h", if_valid, if_pc, if_instruction, RESET_PC + 32'd4, mem_word(RESET_PC));
        end
    endtask

    // Random freeze/branch/latency; decode consumes an item on every cycle
    // without freeze, and a branch flushes whatever is on display.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] r;
        logic [31:0] ba;
        bit          fr;
        bit          br;
        int          idle;
        salt = $urandom;
        do_reset();
        rand_lat = 1'b1;
        exp_pc = RESET_PC + 32'd4;
        idle = 0;
        for (int k = 0; k < 3000; k++) begin
            fr = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 11) == 0);
            r = $urandom;
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : {r[31:2], 2'b00};
            freeze = fr;
            branch_taken = br;
            branch_addr = br ? ba : $urandom;
            if (br) begin
                exp_pc = ba + 32'd4;
                idle = 0;
            end else if (!fr && if_valid) begin
                n_tests++;
                if (if_pc !== exp_pc || if_instruction !== mem_word(if_pc - 32'd4)) begin
                    n_fail++;
                    $display("FAIL rnd_stream cyc %0d got %h/%h required %h/%h", k, if_pc, if_instruction, exp_pc, mem_word(exp_pc - 32'd4));
                end
                exp_pc = if_pc + 32'd4;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 300) begin
                n_tests++;
                n_fail++;
                $display("FAIL rnd_progress no instruction for %0d cycles", idle);
                break;
            end
            step();
        end
        freeze = 1'b0;
        branch_taken = 1'b0;
        rand_lat = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_freeze();
        test_branch_discard();
        test_branch_in_stall();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
